// File: rtl/ise_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ise_pkg
// Purpose  : Shared types and constants for the image sort engine sequencer:
//            colour codes, sequencer states, result-entry layout, defaults.
// Revision : 1.0 - initial release
// ============================================================================
package ise_pkg;

    localparam int IMAGE_NUM_DEF   = 32;
    localparam int PIX_PER_IMG_DEF = 16384;
    localparam int IDX_W_DEF       = 5;

    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CLS  = 2'd1,
        OUT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Result-table entry layout at the default index width.
    typedef struct packed {
        logic [1:0]           color;
        logic [IDX_W_DEF-1:0] idx;
    } res_entry_t;

    // Code 3 is not a legal colour; it is folded onto blue.
    function automatic logic [1:0] sat_color(input logic [1:0] c);
        return (c == 2'd3) ? COL_B : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ise_result_table.sv
`default_nettype none
// ============================================================================
// Module   : ise_result_table
// Purpose  : IMAGE_NUM-entry result register file holding {colour, index}
//            per image; one write port, one asynchronous read port,
//            synchronous active-low clear.
// Revision : 1.0 - initial release
// ============================================================================
module ise_result_table
    import ise_pkg::*;
#(
    parameter int IMAGE_NUM = IMAGE_NUM_DEF,
    parameter int IDX_W     = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             i_clr_n,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [1:0]       i_wr_color,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [IDX_W-1:0] i_rd_addr,
    output logic [1:0]       o_rd_color,
    output logic [IDX_W-1:0] o_rd_idx
);

    logic [1:0]       r_color [IMAGE_NUM];
    logic [IDX_W-1:0] r_idx   [IMAGE_NUM];

    // Clear every entry on reset, otherwise store one result when written.
    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            for (int i = 0; i < IMAGE_NUM; i++) begin
                r_color[i] <= '0;
                r_idx[i]   <= '0;
            end
        end else if (i_we) begin
            r_color[i_wr_addr] <= i_wr_color;
            r_idx[i_wr_addr]   <= i_wr_idx;
        end
    end

    assign o_rd_color = r_color[i_rd_addr];
    assign o_rd_idx   = r_idx[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/ise_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ise_seq_ctrl
// Purpose  : Image sort engine sequencer. Loads images pixel by pixel,
//            requests classification, records each image's dominant colour
//            and finally emits all results grouped red, green, blue.
// Revision : 1.0 - initial release
// ============================================================================
module ise_seq_ctrl
    import ise_pkg::*;
#(
    parameter int IMAGE_NUM   = IMAGE_NUM_DEF,
    parameter int PIX_PER_IMG = PIX_PER_IMG_DEF,
    parameter int IDX_W       = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] image_in_index,
    input  logic             cls_done,
    input  logic [1:0]       cls_color,
    output logic             busy,
    output logic             acc_en,
    output logic             acc_clr,
    output logic             cls_req,
    output logic             out_valid,
    output logic [1:0]       color_index,
    output logic [IDX_W-1:0] image_out_index,
    output logic             done,
    output logic             err
);

    localparam int               PIX_W     = $clog2(PIX_PER_IMG);
    localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_PER_IMG - 1);
    localparam logic [IDX_W-1:0] SLOT_LAST = IDX_W'(IMAGE_NUM - 1);

    state_t           r_state;
    logic [PIX_W-1:0] r_pix_cnt;
    logic [IDX_W-1:0] r_cur_idx;
    logic [IDX_W-1:0] r_wr_ptr;
    logic [1:0]       r_pass;
    logic [IDX_W-1:0] r_slot;
    logic             r_busy;
    logic             r_acc_clr;
    logic             r_cls_req;
    logic             r_out_valid;
    logic [1:0]       r_color_index;
    logic [IDX_W-1:0] r_image_out_index;
    logic             r_done;
    logic             r_err;

    logic             w_accept;
    logic             w_cls_hit;
    logic [1:0]       w_wr_color;
    logic [1:0]       w_rd_color;
    logic [IDX_W-1:0] w_rd_idx;

    // A pixel is taken only while loading and not stalled; classification
    // results count only while actually waiting for one.
    assign w_accept   = in_valid & ~r_busy & (r_state == LOAD);
    assign w_cls_hit  = cls_done & (r_state == CLS);
    assign w_wr_color = sat_color(cls_color);

    ise_result_table #(
        .IMAGE_NUM (IMAGE_NUM),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk        (clk),
        .i_clr_n    (reset),
        .i_we       (w_cls_hit),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_color (w_wr_color),
        .i_wr_idx   (r_cur_idx),
        .i_rd_addr  (r_slot),
        .o_rd_color (w_rd_color),
        .o_rd_idx   (w_rd_idx)
    );

    // Sequencer: load -> classify per image, then a 3-pass scan of the table.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state           <= LOAD;
            r_pix_cnt         <= '0;
            r_cur_idx         <= '0;
            r_wr_ptr          <= '0;
            r_pass            <= '0;
            r_slot            <= '0;
            r_busy            <= 1'b0;
            r_acc_clr         <= 1'b0;
            r_cls_req         <= 1'b0;
            r_out_valid       <= 1'b0;
            r_color_index     <= '0;
            r_image_out_index <= '0;
            r_done            <= 1'b0;
            r_err             <= 1'b0;
        end else begin
            r_acc_clr   <= 1'b0;
            r_cls_req   <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        if (r_pix_cnt == '0) begin
                            r_cur_idx <= image_in_index;
                        end else if (image_in_index != r_cur_idx) begin
                            r_err <= 1'b1;
                        end
                        if (r_pix_cnt == PIX_LAST) begin
                            r_pix_cnt <= '0;
                            r_state   <= CLS;
                            r_busy    <= 1'b1;
                            r_cls_req <= 1'b1;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end
                CLS: begin
                    if (cls_done) begin
                        if (cls_color == 2'd3) begin
                            r_err <= 1'b1;
                        end
                        r_acc_clr <= 1'b1;
                        if (r_wr_ptr == SLOT_LAST) begin
                            r_wr_ptr <= '0;
                            r_state  <= OUT;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                            r_state  <= LOAD;
                            r_busy   <= 1'b0;
                        end
                    end
                end
                OUT: begin
                    r_out_valid       <= (w_rd_color == r_pass);
                    r_color_index     <= r_pass;
                    r_image_out_index <= w_rd_idx;
                    if (r_slot == SLOT_LAST) begin
                        r_slot <= '0;
                        if (r_pass == COL_B) begin
                            r_pass  <= '0;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_pass <= r_pass + 1'b1;
                        end
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign acc_en          = w_accept;
    assign acc_clr         = r_acc_clr;
    assign cls_req         = r_cls_req;
    assign out_valid       = r_out_valid;
    assign color_index     = r_color_index;
    assign image_out_index = r_image_out_index;
    assign done            = r_done;
    assign err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ise_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ise_seq_ctrl
// Purpose  : Self-checking bench for ise_seq_ctrl with 4 images of 4 pixels.
//            Run records drive whole runs; results are checked in order
//            against a queue of expected {colour, index} pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ise_seq_ctrl;

    localparam int IMG = 4;
    localparam int PIX = 4;
    localparam int IW  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] image_in_index = '0;
    logic          cls_done = 1'b0;
    logic [1:0]    cls_color = '0;
    logic          busy, acc_en, acc_clr, cls_req, out_valid, done, err;
    logic [1:0]    color_index;
    logic [IW-1:0] image_out_index;

    int n_tests = 0;
    int n_fail  = 0;
    int clr_cnt = 0;
    int ov_cnt  = 0;
    logic [3:0] exp_q[$];

    typedef struct {
        logic [3:0][1:0] col;
        int              dly;
        int              gimg;
        int              gpix;
        logic            exp_err;
    } rec_t;

    rec_t recs[6];

    ise_seq_ctrl #(
        .IMAGE_NUM   (IMG),
        .PIX_PER_IMG (PIX),
        .IDX_W       (IW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .image_in_index  (image_in_index),
        .cls_done        (cls_done),
        .cls_color       (cls_color),
        .busy            (busy),
        .acc_en          (acc_en),
        .acc_clr         (acc_clr),
        .cls_req         (cls_req),
        .out_valid       (out_valid),
        .color_index     (color_index),
        .image_out_index (image_out_index),
        .done            (done),
        .err             (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic rec_t mk(input logic [1:0] c0, input logic [1:0] c1,
                                input logic [1:0] c2, input logic [1:0] c3,
                                input int dly, input int gimg, input int gpix,
                                input logic e);
        rec_t r;
        r.col[0] = c0; r.col[1] = c1; r.col[2] = c2; r.col[3] = c3;
        r.dly = dly; r.gimg = gimg; r.gpix = gpix; r.exp_err = e;
        return r;
    endfunction

    // Scoreboard side: every result pulse must match the next expected pair.
    always @(negedge clk) begin
        if (reset && acc_clr) clr_cnt++;
        if (reset && out_valid) begin
            ov_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'd1, 32'd0);
            end else begin
                chk("out_order", {28'd0, color_index, image_out_index}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    // Present n pixels of image img; pixel gpix carries a wrong index.
    task automatic feed_pixels(input int img, input int n, input int gpix);
        for (int p = 0; p < n; p++) begin
            in_valid       = 1'b1;
            image_in_index = (p == gpix) ? IW'(img ^ 1) : IW'(img);
            #1;
            chk("acc_en_load", {31'd0, acc_en}, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    // Classification handshake for one image, cls_done after dly cycles.
    task automatic classify(input int img, input logic [1:0] col, input int dly);
        chk("busy_after_last_pix", {31'd0, busy}, 32'd1);
        chk("cls_req_first", {31'd0, cls_req}, 32'd1);
        image_in_index = IW'(img);
        cls_color      = col;
        for (int d = 0; d < dly; d++) begin
            #1;
            chk("no_accept_in_cls", {31'd0, acc_en}, 32'd0);
            step();
            chk("cls_req_single", {31'd0, cls_req}, 32'd0);
        end
        cls_done = 1'b1;
        #1;
        chk("no_accept_in_cls", {31'd0, acc_en}, 32'd0);
        step();
        cls_done = 1'b0;
        chk("acc_clr_pulse", {31'd0, acc_clr}, 32'd1);
        chk("busy_after_cls", {31'd0, busy}, (img == IMG - 1) ? 32'd1 : 32'd0);
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        cls_done = 1'b0;
        step();
        step();
        chk("reset_state",
            {23'd0, busy, acc_clr, cls_req, out_valid, color_index, image_out_index, done, err},
            32'd0);
        reset = 1'b1;
    endtask

    task automatic run_record(input rec_t r);
        int k;
        logic [1:0] eff;
        apply_reset();
        exp_q.delete();
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < IMG; s++) begin
                eff = (r.col[s] == 2'd3) ? 2'd2 : r.col[s];
                if (int'(eff) == p) exp_q.push_back({2'(p), 2'(s)});
            end
        end
        clr_cnt = 0;
        ov_cnt  = 0;
        for (int img = 0; img < IMG; img++) begin
            feed_pixels(img, PIX, (img == r.gimg) ? r.gpix : -1);
            classify(img, r.col[img], r.dly);
        end
        in_valid = 1'b0;
        k = 0;
        while (k < 40) begin
            step();
            k++;
            if (done) break;
        end
        chk("done_latency", k, 32'd12);
        step();
        step();
        chk("done_state", {29'd0, busy, done, out_valid}, 32'b110);
        chk("out_valid_count", ov_cnt, IMG);
        chk("exp_queue_drained", exp_q.size(), 32'd0);
        chk("acc_clr_count", clr_cnt, IMG);
        chk("err_flag", {31'd0, err}, {31'd0, r.exp_err});
    endtask

    initial begin
        recs[0] = mk(2'd0, 2'd0, 2'd0, 2'd0, 1, -1, -1, 1'b0);
        recs[1] = mk(2'd2, 2'd1, 2'd0, 2'd1, 1, -1, -1, 1'b0);
        recs[2] = mk(2'd1, 2'd1, 2'd2, 2'd0, 0, -1, -1, 1'b0);
        recs[3] = mk(2'd0, 2'd2, 2'd1, 2'd2, 7, -1, -1, 1'b0);
        recs[4] = mk(2'd0, 2'd1, 2'd2, 2'd0, 1,  1,  2, 1'b1);
        recs[5] = mk(2'd0, 2'd1, 2'd3, 2'd1, 2, -1, -1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            run_record(recs[i]);
        end

        // Abort a run two pixels into image 1, then run a clean one.
        apply_reset();
        exp_q.delete();
        feed_pixels(0, PIX, -1);
        classify(0, 2'd1, 1);
        feed_pixels(1, 2, -1);
        reset = 1'b0;
        step();
        chk("mid_reset_outputs",
            {23'd0, busy, acc_clr, cls_req, out_valid, color_index, image_out_index, done, err},
            32'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        run_record(recs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ise_seq_ctrl.md
Name: ise_seq_ctrl

Overview:
- Top-level sequencer for the image sort engine (ISE) datapath.
- Accepts the pixel stream image by image and drives busy.
- Tells the colour accumulator datapath when to accumulate, classify and clear.
- Records each image's dominant colour, then emits all results grouped by colour (red, green, blue), arrival order within a group, on out_valid/color_index/image_out_index.

Parameters:
- IMAGE_NUM, 32, images per run (power of two, ≥2).
- PIX_PER_IMG, 16384, pixels per image (128x128).
- IDX_W, 5, image index width = log2(IMAGE_NUM).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  pixel_in/image_in_index valid this cycle
- image_in_index  in  IDX_W  index of image the current pixel belongs to
- cls_done  in  1  datapath: classification result valid (single-cycle pulse)
- cls_color  in  2  datapath: dominant colour, 0=R 1=G 2=B
- busy  out  1  registered; 1 = source must not present pixels
- acc_en  out  1  combinational; accumulate current pixel_in
- acc_clr  out  1  registered one-cycle pulse; clear accumulators
- cls_req  out  1  registered one-cycle pulse; start classification
- out_valid  out  1  registered; result on color_index/image_out_index
- color_index  out  2  registered result colour
- image_out_index  out  IDX_W  registered result image index
- done  out  1  registered; all results emitted
- err  out  1  registered sticky; index mismatch or cls_color==3

Behaviour:
- Reset (reset==0 at posedge):
  - state=LOAD; all counters/pointers=0; result table cleared.
  - busy=0, acc_clr=0, cls_req=0, out_valid=0, color_index=0, image_out_index=0, done=0, err=0.
- States: LOAD, CLS, OUT, DONE.
- LOAD:
  - Acceptance = in_valid & ~busy; acc_en = acceptance.
  - pix_cnt (log2(PIX_PER_IMG) bits) increments per acceptance.
  - First pixel of an image (pix_cnt==0): latch image_in_index into cur_idx.
  - Later pixels: image_in_index != cur_idx sets err; the pixel is still counted.
  - Acceptance with pix_cnt==PIX_PER_IMG-1: pix_cnt wraps to 0, go to CLS, busy=1 and cls_req=1 from the next cycle.
  - in_valid while busy=1 is ignored.
- CLS:
  - busy=1; cls_req high only on the first CLS cycle.
  - Waits indefinitely for cls_done; cls_done is honoured on any CLS cycle, including the cls_req cycle; cls_done outside CLS is ignored.
  - On cls_done:
    - table[wr_ptr]={cls_color,cur_idx}; cls_color==3 is stored as 2 and sets err.
    - acc_clr=1 next cycle.
    - If wr_ptr==IMAGE_NUM-1: go to OUT, wr_ptr wraps to 0.
    - Else: wr_ptr++, go to LOAD, busy=0 next cycle.
- OUT:
  - busy=1. Nested scan: pass p=0..2, slot s=0..IMAGE_NUM-1, one slot per cycle, 3*IMAGE_NUM cycles total.
  - Next cycle: out_valid=(table[s].color==p), color_index=p, image_out_index=table[s].idx.
  - When out_valid=0, color_index/image_out_index still update but are don't-care.
  - Exactly IMAGE_NUM out_valid pulses per run.
  - After p=2, s=IMAGE_NUM-1: go to DONE.
- DONE:
  - busy=1, done=1, out_valid=0; held until reset.
- Latency:
  - Last pixel accepted → busy high: 1 cycle.
  - cls_done → busy low: 1 cycle.
  - First OUT cycle → first out_valid: 1 cycle.
- Reset mid-operation aborts any state; partially accumulated image and table are discarded.

Decomposition:
- Package ise_pkg:
  - Colour constants COL_R=0, COL_G=1, COL_B=2.
  - State enum {LOAD, CLS, OUT, DONE}.
  - Result-entry struct {color[1:0], idx[IDX_W-1:0]}.
  - IMAGE_NUM/PIX_PER_IMG defaults.
- One sub-module: ise_result_table
  - IMAGE_NUM-entry register file, 1 write port, 1 async read port.
  - Synchronous active-low clear.

Test Plan:
- PIX_PER_IMG=4, IMAGE_NUM=4, in_valid always 1, cls_done 1 cycle after cls_req, colours R,R,R,R → busy high 1 cycle after each 4th pixel; 4 outputs (0,0),(0,1),(0,2),(0,3) in slots 0-3 of pass 0; done after 12 OUT cycles.
- Colours B,G,R,G for images 0-3 → outputs in order (0,2),(1,1),(1,3),(2,0); exactly 4 out_valid pulses; err=0.
- cls_done in the same cycle as cls_req, and again 7 cycles late → both captured; no pixel accepted during CLS; acc_clr pulses once per image.
- image_in_index changes mid-image (image 1, pixel 2) → err=1 sticky; pixel still counted; sequencing unaffected.
- cls_color=3 for image 2 → stored as B, emitted in pass 2, err=1.
- reset=0 after 2 pixels of image 1 → all outputs at reset values next cycle; fresh run from image 0 completes correctly.
